lc4_ss_issue_sched: RTL and testbench



---
 rtl/lc4_ss_pkg.sv | 41 ++++
 rtl/lc4_ss_issue_sched_if.sv | 32 +++
 rtl/lc4_ss_scoreboard.sv | 35 +++
 rtl/lc4_ss_issue_sched.sv | 105 ++++++++++
 tb/tb_lc4_ss_issue_sched.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc4_ss_pkg.sv
// Shared micro-op layout and hazard helpers for the LC4 dual-issue scheduler.
package lc4_ss_pkg;

   localparam int UOP_W      = 16;
   localparam int RS_LSB     = 0;
   localparam int RS_RE_BIT  = 3;
   localparam int RT_LSB     = 4;
   localparam int RT_RE_BIT  = 7;
   localparam int RD_LSB     = 8;
   localparam int RD_WE_BIT  = 11;
   localparam int LOAD_BIT   = 12;
   localparam int STORE_BIT  = 13;
   localparam int BRANCH_BIT = 14;

   // Field order mirrors the bit offsets above, MSB first; bit 15 is reserved.
   typedef struct packed {
      logic       spare;
      logic       is_branch;
      logic       is_store;
      logic       is_load;
      logic       rd_we;
      logic [2:0] rd;
      logic       rt_re;
      logic [2:0] rt;
      logic       rs_re;
      logic [2:0] rs;
   } uop_t;

   function automatic logic uop_reads(input uop_t uop, input logic [2:0] r);
      return (uop.rs_re && (uop.rs == r)) || (uop.rt_re && (uop.rt == r));
   endfunction

   function automatic logic uop_src_busy(input uop_t uop, input logic [7:0] busy);
      return (uop.rs_re && busy[uop.rs]) || (uop.rt_re && busy[uop.rt]);
   endfunction

   function automatic logic uop_is_mem(input uop_t uop);
      return uop.is_load || uop.is_store;
   endfunction

endpackage

// File: rtl/lc4_ss_issue_sched_if.sv
// Decode-to-scheduler-to-pipes bundle; master is the decode/pipe side, slave is the scheduler.
interface lc4_ss_issue_sched_if #(
   parameter int QDEPTH = 4
);
   import lc4_ss_pkg::*;

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [UOP_W-1:0] i_uop0;
   logic             i_valid0;
   logic [UOP_W-1:0] i_uop1;
   logic             i_valid1;
   logic             o_enq_ready;
   logic             i_flush;
   logic             i_stall;
   logic [UOP_W-1:0] o_uop_A;
   logic             o_valid_A;
   logic [UOP_W-1:0] o_uop_B;
   logic             o_valid_B;
   logic [CW-1:0]    o_count;

   modport master (
      output i_uop0, i_valid0, i_uop1, i_valid1, i_flush, i_stall,
      input  o_enq_ready, o_uop_A, o_valid_A, o_uop_B, o_valid_B, o_count
   );

   modport slave (
      input  i_uop0, i_valid0, i_uop1, i_valid1, i_flush, i_stall,
      output o_enq_ready, o_uop_A, o_valid_A, o_uop_B, o_valid_B, o_count
   );

endinterface

// File: rtl/lc4_ss_scoreboard.sv
// Per-register load-latency scoreboard: a register is busy while its counter is nonzero.
module lc4_ss_scoreboard #(
   parameter int LOAD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance,
   input  logic [7:0] ld_set,
   output logic [7:0] busy
);

   localparam int SW = $clog2(LOAD_LAT + 1);

   logic [SW-1:0] sb [8];

   // A fresh load overrides the decrement, so a same-register reload restarts the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 8; r++) sb[r] <= '0;
      end else if (advance) begin
         for (int r = 0; r < 8; r++) begin
            if (ld_set[r])
               sb[r] <= SW'(LOAD_LAT);
            else if (sb[r] != '0)
               sb[r] <= sb[r] - SW'(1);
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int r = 0; r < 8; r++) busy[r] = (sb[r] != '0);
   end

endmodule

// File: rtl/lc4_ss_issue_sched.sv
// In-order dual-issue scheduler: oldest queued micro-op to pipe A, next-oldest to pipe B when legal.
module lc4_ss_issue_sched
   import lc4_ss_pkg::*;
#(
   parameter int QDEPTH   = 4,
   parameter int LOAD_LAT = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   lc4_ss_issue_sched_if.slave bus
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   uop_t          q [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   uop_t          h0;
   uop_t          h1;
   logic [7:0]    busy;
   logic [7:0]    ld_set;
   logic          issue_a;
   logic          issue_b;
   logic          enq_ready;
   logic          enq_fire;
   logic          enq_two;
   logic [1:0]    enq_n;
   logic [1:0]    deq_n;

   assign h0 = q[head];
   assign h1 = q[head + PW'(1)];

   // Ready looks only at the registered count; a same-cycle dequeue earns no credit.
   assign enq_ready = (QDEPTH - int'(count)) >= 2;
   assign enq_fire  = enq_ready && bus.i_valid0 && !bus.i_flush;
   assign enq_two   = enq_fire && bus.i_valid1;
   assign enq_n     = enq_two ? 2'd2 : (enq_fire ? 2'd1 : 2'd0);

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      issue_a = 1'b0;
      issue_b = 1'b0;
      ld_set  = '0;

      issue_a = (count != '0) && !bus.i_stall && !bus.i_flush && !uop_src_busy(h0, busy);

      // WAW between H0 and H1 is legal: the regfile lets pipe B win, matching program order.
      issue_b = issue_a
             && (count >= CW'(2))
             && !uop_src_busy(h1, busy)
             && !(h0.rd_we && uop_reads(h1, h0.rd))
             && !(uop_is_mem(h0) && uop_is_mem(h1))
             && !h0.is_branch;

      for (int r = 0; r < 8; r++) begin
         ld_set[r] = (issue_a && h0.is_load && h0.rd_we && (h0.rd == 3'(r)))
                  || (issue_b && h1.is_load && h1.rd_we && (h1.rd == 3'(r)));
      end
   end

   assign deq_n = {1'b0, issue_a} + {1'b0, issue_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.i_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq_n);
         tail  <= tail + PW'(enq_n);
         count <= count + CW'(enq_n) - CW'(deq_n);
      end
   end

   // NOTE: queue storage has no reset; count gates every read, so stale entries are never issued.
   always_ff @(posedge clk) begin
      if (enq_fire) q[tail]          <= uop_t'(bus.i_uop0);
      if (enq_two)  q[tail + PW'(1)] <= uop_t'(bus.i_uop1);
   end

   lc4_ss_scoreboard #(
      .LOAD_LAT (LOAD_LAT)
   ) u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (!bus.i_stall),
      .ld_set  (ld_set),
      .busy    (busy)
   );

   assign bus.o_enq_ready = enq_ready;
   assign bus.o_uop_A     = h0;
   assign bus.o_valid_A   = issue_a;
   assign bus.o_uop_B     = h1;
   assign bus.o_valid_B   = issue_b;
   assign bus.o_count     = count;

endmodule

// File: tb/tb_lc4_ss_issue_sched.sv
// Directed bench: stimulus pushes expected issues (uop, pipe, cycle) into a queue; a monitor pops and compares.
module tb_lc4_ss_issue_sched;
   import lc4_ss_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;

   typedef struct {
      logic [UOP_W-1:0] uop;
      int               pipe;
      int               cyc;
   } exp_t;

   exp_t exp_q[$];

   lc4_ss_issue_sched_if #(.QDEPTH(4)) bus ();

   lc4_ss_issue_sched #(
      .QDEPTH   (4),
      .LOAD_LAT (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   function automatic uop_t mk(input logic [2:0] rd, input logic we,
                               input logic [2:0] rs, input logic rs_re,
                               input logic [2:0] rt, input logic rt_re,
                               input logic ld, input logic st, input logic br);
      uop_t u;
      u = '0;
      u.rd = rd; u.rd_we = we;
      u.rs = rs; u.rs_re = rs_re;
      u.rt = rt; u.rt_re = rt_re;
      u.is_load = ld; u.is_store = st; u.is_branch = br;
      return u;
   endfunction

   function automatic uop_t alu(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
      return mk(rd, 1'b1, rs, 1'b1, rt, 1'b1, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic uop_t ldr(input logic [2:0] rd, input logic [2:0] base);
      return mk(rd, 1'b1, base, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endfunction

   function automatic uop_t str(input logic [2:0] src, input logic [2:0] base);
      return mk(3'd0, 1'b0, base, 1'b1, src, 1'b1, 1'b0, 1'b1, 1'b0);
   endfunction

   function automatic uop_t brz();
      return mk(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction

   task automatic expect_issue(input uop_t u, input int pipe, input int at);
      exp_t e;
      e.uop = u; e.pipe = pipe; e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input uop_t a, input logic va, input uop_t b, input logic vb);
      bus.i_uop0 = a; bus.i_valid0 = va;
      bus.i_uop1 = b; bus.i_valid1 = vb;
   endtask

   task automatic idle();
      drive('0, 1'b0, '0, 1'b0);
   endtask

   task automatic settle();
      repeat (3) tick();
   endtask

   // Monitor: every presented valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.o_valid_A) begin
            if (exp_q.size() == 0) check("unexpected_A", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("A_pipe", 0, e.pipe);
               check("A_uop", int'(bus.o_uop_A), int'(e.uop));
               check("A_cycle", cyc, e.cyc);
            end
         end
         if (bus.o_valid_B) begin
            if (exp_q.size() == 0) check("unexpected_B", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("B_pipe", 1, e.pipe);
               check("B_uop", int'(bus.o_uop_B), int'(e.uop));
               check("B_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e;
      idle();
      bus.i_flush = 1'b0;
      bus.i_stall = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_count", int'(bus.o_count), 0);
      check("rst_ready", int'(bus.o_enq_ready), 1);
      check("rst_valid_A", int'(bus.o_valid_A), 0);
      check("rst_valid_B", int'(bus.o_valid_B), 0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // 1: independent pair dual-issues the cycle after enqueue
      e = cyc;
      drive(alu(1, 2, 3), 1'b1, alu(4, 5, 6), 1'b1);
      expect_issue(alu(1, 2, 3), 0, e + 1);
      expect_issue(alu(4, 5, 6), 1, e + 1);
      tick(); idle();
      @(negedge clk) check("t1_count_before", int'(bus.o_count), 2);
      tick();
      @(negedge clk) check("t1_count_after", int'(bus.o_count), 0);
      settle();

      // WAW pair is legal for dual issue
      e = cyc;
      drive(alu(1, 2, 3), 1'b1, alu(1, 4, 5), 1'b1);
      expect_issue(alu(1, 2, 3), 0, e + 1);
      expect_issue(alu(1, 4, 5), 1, e + 1);
      tick(); idle();
      settle();

      // 2: RAW inside the pair splits it
      e = cyc;
      drive(alu(1, 2, 3), 1'b1, alu(4, 1, 5), 1'b1);
      expect_issue(alu(1, 2, 3), 0, e + 1);
      expect_issue(alu(4, 1, 5), 0, e + 2);
      tick(); idle();
      tick();
      @(negedge clk) check("t2_count_mid", int'(bus.o_count), 1);
      tick();
      @(negedge clk) check("t2_count_end", int'(bus.o_count), 0);
      settle();

      // 3: load-use across cycles
      e = cyc;
      drive(ldr(2, 7), 1'b1, '0, 1'b0);
      expect_issue(ldr(2, 7), 0, e + 1);
      tick();
      drive(alu(3, 2, 2), 1'b1, '0, 1'b0);
      expect_issue(alu(3, 2, 2), 0, e + 3);
      tick(); idle();
      @(negedge clk) check("t3_consumer_held", int'(bus.o_count), 1);
      settle();

      // B source busy from an earlier load
      e = cyc;
      drive(ldr(6, 0), 1'b1, '0, 1'b0);
      expect_issue(ldr(6, 0), 0, e + 1);
      tick();
      drive(alu(3, 1, 1), 1'b1, alu(2, 6, 6), 1'b1);
      expect_issue(alu(3, 1, 1), 0, e + 2);
      expect_issue(alu(2, 6, 6), 0, e + 3);
      tick(); idle();
      settle();

      // 4: two memory ops, then branch followed by ALU
      e = cyc;
      drive(ldr(1, 0), 1'b1, str(2, 3), 1'b1);
      expect_issue(ldr(1, 0), 0, e + 1);
      expect_issue(str(2, 3), 0, e + 2);
      tick(); idle();
      settle();
      e = cyc;
      drive(brz(), 1'b1, alu(5, 6, 6), 1'b1);
      expect_issue(brz(), 0, e + 1);
      expect_issue(alu(5, 6, 6), 0, e + 2);
      tick(); idle();
      settle();

      // 5: fill under stall, then flush wins over enqueue and issue
      bus.i_stall = 1'b1;
      drive(alu(1, 1, 1), 1'b1, alu(2, 2, 2), 1'b1);
      tick();
      drive(alu(3, 3, 3), 1'b1, alu(4, 4, 4), 1'b1);
      @(negedge clk) check("t5_ready_half", int'(bus.o_enq_ready), 1);
      tick();
      bus.i_stall = 1'b0;
      bus.i_flush = 1'b1;
      drive(alu(7, 7, 7), 1'b1, '0, 1'b0);
      @(negedge clk);
      check("t5_count_full", int'(bus.o_count), 4);
      check("t5_ready_full", int'(bus.o_enq_ready), 0);
      check("t5_flush_valid_A", int'(bus.o_valid_A), 0);
      check("t5_flush_valid_B", int'(bus.o_valid_B), 0);
      tick();
      bus.i_flush = 1'b0;
      idle();
      @(negedge clk);
      check("t5_count_flushed", int'(bus.o_count), 0);
      check("t5_ready_flushed", int'(bus.o_enq_ready), 1);
      tick();
      bus.i_flush = 1'b1;
      drive(alu(5, 5, 5), 1'b1, alu(6, 6, 6), 1'b1);
      tick();
      bus.i_flush = 1'b0;
      idle();
      @(negedge clk) check("t5_enq_dropped", int'(bus.o_count), 0);
      settle();

      // 6: stall freezes the scoreboard while a load is pending
      e = cyc;
      drive(ldr(4, 0), 1'b1, '0, 1'b0);
      expect_issue(ldr(4, 0), 0, e + 1);
      tick();
      drive(alu(5, 4, 4), 1'b1, '0, 1'b0);
      tick();
      idle();
      bus.i_stall = 1'b1;
      @(negedge clk) check("t6_count_stalled", int'(bus.o_count), 1);
      tick(); tick(); tick();
      bus.i_stall = 1'b0;
      expect_issue(alu(5, 4, 4), 0, e + 6);
      settle();

      // Reset mid-operation discards queued work
      bus.i_stall = 1'b1;
      drive(alu(1, 2, 3), 1'b1, alu(4, 5, 6), 1'b1);
      tick(); idle();
      @(negedge clk) check("rst_mid_count_before", int'(bus.o_count), 2);
      rst_n = 1'b0;
      #1;
      check("rst_mid_count", int'(bus.o_count), 0);
      check("rst_mid_ready", int'(bus.o_enq_ready), 1);
      bus.i_stall = 1'b0;
      tick();
      @(negedge clk) rst_n = 1'b1;
      settle();
      check("rst_mid_count_after", int'(bus.o_count), 0);

      check("expectations_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
